fpnew_divsqrt_th_32_wb_ctrl: RTL and testbench

Issue/writeback controller wrapped around the 32-bit T-Head div/sqrt core inside the FPU divsqrt slice. It accepts operations from the FPU input handshake and pulses the core's start strobe. It captures the core's single-cycle writeback pulse and holds the result until the FPU output handshake drains it. It enforces the invariant that an operation never starts while a writeback is in flight.

---
 rtl/fpnew_divsqrt_th_32_pkg.sv | 21 ++
 rtl/fpnew_divsqrt_th_32_wb_ctrl.sv | 139 +++++++++++++
 tb/tb_fpnew_divsqrt_th_32_wb_ctrl.sv | 298 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/fpnew_divsqrt_th_32_pkg.sv
// Shared types for the T-Head 32-bit div/sqrt writeback controller.
package fpnew_divsqrt_th_32_pkg;

    localparam int unsigned NUM_FLAGS = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        HOLD = 2'd2,
        KILL = 2'd3
    } state_e;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } status_t;

endpackage

// File: rtl/fpnew_divsqrt_th_32_wb_ctrl.sv
// Issue/writeback controller around the T-Head div/sqrt core: strobes start,
// captures the single-cycle writeback and holds it until the FPU drains it.
module fpnew_divsqrt_th_32_wb_ctrl
    import fpnew_divsqrt_th_32_pkg::*;
#(
    parameter int unsigned TAG_WIDTH = 1,
    parameter int unsigned CNT_WIDTH = 6
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [TAG_WIDTH-1:0] in_tag_i,
    input  logic                 flush_i,
    output logic                 start_o,
    output logic                 unit_ready_o,
    input  logic                 res_valid_i,
    input  logic [31:0]          res_data_i,
    input  logic [NUM_FLAGS-1:0] res_status_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [31:0]          result_o,
    output logic [NUM_FLAGS-1:0] status_o,
    output logic [TAG_WIDTH-1:0] tag_o,
    output logic                 busy_o,
    output logic [CNT_WIDTH-1:0] lat_o,
    output logic                 err_o
);

    state_e                 state_q, state_d;
    logic [31:0]            result_q, result_d;
    status_t                status_q, status_d;
    logic [TAG_WIDTH-1:0]   tag_q, tag_d;
    logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
    logic [CNT_WIDTH-1:0]   lat_q, lat_d;
    logic                   err_q, err_d;
    logic                   unit_ready_q, unit_ready_d;
    logic [CNT_WIDTH-1:0]   cnt_sat_inc;
    logic                   in_ready;
    logic                   start;

    // Valid/ready: an op is accepted when in_valid_i && in_ready_o in the same
    // cycle; a held result is consumed when out_valid_o && out_ready_i.
    assign in_ready = !flush_i && ((state_q == IDLE) || ((state_q == HOLD) && out_ready_i));
    assign start    = in_valid_i && in_ready;

    assign cnt_sat_inc = (cnt_q == {CNT_WIDTH{1'b1}}) ? cnt_q : cnt_q + CNT_WIDTH'(1);

    always_comb begin
        state_d  = state_q;
        result_d = result_q;
        status_d = status_q;
        tag_d    = tag_q;
        cnt_d    = cnt_q;
        lat_d    = lat_q;
        err_d    = err_q;

        // Writebacks while no op is in the core, or racing a new start, are protocol errors.
        if (res_valid_i && ((state_q == IDLE) || (state_q == HOLD) || start)) begin
            err_d = 1'b1;
        end

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = BUSY;
                    tag_d   = in_tag_i;
                    cnt_d   = '0;
                end
            end
            BUSY: begin
                cnt_d = cnt_sat_inc;
                if (flush_i) begin
                    state_d = res_valid_i ? IDLE : KILL;
                end else if (res_valid_i) begin
                    state_d  = HOLD;
                    result_d = res_data_i;
                    status_d = status_t'(res_status_i);
                    lat_d    = cnt_sat_inc;
                end
            end
            HOLD: begin
                if (flush_i) begin
                    state_d = IDLE;
                end else if (out_ready_i) begin
                    if (start) begin
                        state_d = BUSY;
                        tag_d   = in_tag_i;
                        cnt_d   = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            KILL: begin
                if (res_valid_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        unit_ready_d = (state_d == IDLE) || (state_d == HOLD);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= IDLE;
            result_q     <= '0;
            status_q     <= '0;
            tag_q        <= '0;
            cnt_q        <= '0;
            lat_q        <= '0;
            err_q        <= 1'b0;
            unit_ready_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            result_q     <= result_d;
            status_q     <= status_d;
            tag_q        <= tag_d;
            cnt_q        <= cnt_d;
            lat_q        <= lat_d;
            err_q        <= err_d;
            unit_ready_q <= unit_ready_d;
        end
    end

    assign in_ready_o   = in_ready;
    assign start_o      = start;
    assign unit_ready_o = unit_ready_q;
    assign out_valid_o  = (state_q == HOLD);
    assign result_o     = result_q;
    assign status_o     = status_q;
    assign tag_o        = tag_q;
    assign busy_o       = (state_q != IDLE);
    assign lat_o        = lat_q;
    assign err_o        = err_q;

endmodule

// File: tb/tb_fpnew_divsqrt_th_32_wb_ctrl.sv
// Directed bench for the div/sqrt writeback controller with hand-computed expectations.
module tb_fpnew_divsqrt_th_32_wb_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [0:0]  in_tag;
    logic        flush;
    logic        start;
    logic        unit_ready;
    logic        res_valid;
    logic [31:0] res_data;
    logic [4:0]  res_status;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic [4:0]  status;
    logic [0:0]  tag;
    logic        busy;
    logic [5:0]  lat;
    logic        err;

    int n_checks = 0;
    int n_fail   = 0;

    fpnew_divsqrt_th_32_wb_ctrl #(
        .TAG_WIDTH(1),
        .CNT_WIDTH(6)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .in_valid_i   (in_valid),
        .in_ready_o   (in_ready),
        .in_tag_i     (in_tag),
        .flush_i      (flush),
        .start_o      (start),
        .unit_ready_o (unit_ready),
        .res_valid_i  (res_valid),
        .res_data_i   (res_data),
        .res_status_i (res_status),
        .out_valid_o  (out_valid),
        .out_ready_i  (out_ready),
        .result_o     (result),
        .status_o     (status),
        .tag_o        (tag),
        .busy_o       (busy),
        .lat_o        (lat),
        .err_o        (err)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_wb();
        res_valid  = 1'b0;
        res_data   = 32'h0;
        res_status = 5'h0;
    endtask

    task automatic writeback(input logic [31:0] d, input logic [4:0] s);
        res_valid  = 1'b1;
        res_data   = d;
        res_status = s;
    endtask

    initial begin
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_tag    = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        clear_wb();
        repeat (3) @(posedge clk);
        #1;
        check("rst_unit_ready", {31'h0, unit_ready}, 32'd1);
        check("rst_out_valid",  {31'h0, out_valid},  32'd0);
        check("rst_result",     result,              32'h0);
        check("rst_status",     {27'h0, status},     32'h0);
        check("rst_tag",        {31'h0, tag},        32'h0);
        check("rst_lat",        {26'h0, lat},        32'h0);
        check("rst_err",        {31'h0, err},        32'h0);
        check("rst_busy",       {31'h0, busy},       32'h0);
        rst_n = 1'b1;
        tick();

        // Single op, core latency 12
        in_valid = 1'b1; in_tag = 1'b1;
        settle();
        check("op1_in_ready", {31'h0, in_ready}, 32'd1);
        check("op1_start",    {31'h0, start},    32'd1);
        tick();
        in_valid = 1'b0;
        settle();
        check("op1_busy",       {31'h0, busy},       32'd1);
        check("op1_unit_ready", {31'h0, unit_ready}, 32'd0);
        check("op1_start_low",  {31'h0, start},      32'd0);
        check("op1_no_out",     {31'h0, out_valid},  32'd0);
        repeat (11) tick();
        writeback(32'h3F80_0000, 5'b00001);
        tick();
        clear_wb();
        settle();
        check("op1_out_valid",  {31'h0, out_valid},  32'd1);
        check("op1_result",     result,              32'h3F80_0000);
        check("op1_status",     {27'h0, status},     32'h1);
        check("op1_tag",        {31'h0, tag},        32'h1);
        check("op1_lat",        {26'h0, lat},        32'd12);
        check("op1_unit_ready_hold", {31'h0, unit_ready}, 32'd1);

        // Backpressure in HOLD, then drain + start in the same cycle
        in_valid = 1'b1; in_tag = 1'b0; out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            settle();
            check("bp_out_valid", {31'h0, out_valid}, 32'd1);
            check("bp_result",    result,             32'h3F80_0000);
            check("bp_tag",       {31'h0, tag},       32'h1);
            check("bp_in_ready",  {31'h0, in_ready},  32'd0);
            check("bp_start",     {31'h0, start},     32'd0);
            tick();
        end
        out_ready = 1'b1;
        settle();
        check("b2b_in_ready", {31'h0, in_ready}, 32'd1);
        check("b2b_start",    {31'h0, start},    32'd1);
        tick();
        in_valid = 1'b0; out_ready = 1'b0;
        settle();
        check("b2b_busy",      {31'h0, busy},       32'd1);
        check("b2b_out_valid", {31'h0, out_valid},  32'd0);
        check("b2b_unit_rdy",  {31'h0, unit_ready}, 32'd0);
        repeat (2) tick();
        writeback(32'h4000_0000, 5'b10000);
        tick();
        clear_wb();
        settle();
        check("op2_out_valid", {31'h0, out_valid}, 32'd1);
        check("op2_result",    result,             32'h4000_0000);
        check("op2_status",    {27'h0, status},    32'h10);
        check("op2_tag",       {31'h0, tag},       32'h0);
        check("op2_lat",       {26'h0, lat},       32'd3);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        check("drain_busy",      {31'h0, busy},       32'd0);
        check("drain_out_valid", {31'h0, out_valid},  32'd0);
        check("drain_unit_rdy",  {31'h0, unit_ready}, 32'd1);

        // Flush in BUSY at cycle 3, orphan writeback at cycle 12
        in_valid = 1'b1; in_tag = 1'b1;
        tick();
        in_valid = 1'b0;
        repeat (2) tick();
        flush = 1'b1;
        settle();
        check("fl_in_ready", {31'h0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b1;
        settle();
        check("kill_busy",     {31'h0, busy},       32'd1);
        check("kill_start",    {31'h0, start},      32'd0);
        check("kill_in_ready", {31'h0, in_ready},   32'd0);
        check("kill_unit_rdy", {31'h0, unit_ready}, 32'd0);
        repeat (8) tick();
        writeback(32'h1234_5678, 5'b00100);
        in_valid = 1'b0;
        tick();
        clear_wb();
        settle();
        check("kill_out_valid", {31'h0, out_valid},  32'd0);
        check("kill_idle",      {31'h0, busy},       32'd0);
        check("kill_unit_rdy2", {31'h0, unit_ready}, 32'd1);
        check("kill_err",       {31'h0, err},        32'd0);
        check("kill_result",    result,              32'h4000_0000);

        // Flush and writeback in the same BUSY cycle go straight to IDLE
        in_valid = 1'b1; in_tag = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        flush = 1'b1;
        writeback(32'hAAAA_5555, 5'b00011);
        tick();
        flush = 1'b0;
        clear_wb();
        settle();
        check("flwb_busy",      {31'h0, busy},      32'd0);
        check("flwb_out_valid", {31'h0, out_valid}, 32'd0);
        check("flwb_err",       {31'h0, err},       32'd0);
        check("flwb_result",    result,             32'h4000_0000);

        // Flush in HOLD drops the result and suppresses a start
        in_valid = 1'b1; in_tag = 1'b1;
        tick();
        in_valid = 1'b0;
        writeback(32'h3F00_0000, 5'b00000);
        tick();
        clear_wb();
        settle();
        check("fh_out_valid", {31'h0, out_valid}, 32'd1);
        check("fh_lat",       {26'h0, lat},       32'd1);
        flush = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
        settle();
        check("fh_start",    {31'h0, start},    32'd0);
        check("fh_in_ready", {31'h0, in_ready}, 32'd0);
        tick();
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        settle();
        check("fh_busy",       {31'h0, busy},      32'd0);
        check("fh_out_valid2", {31'h0, out_valid}, 32'd0);

        // Stray writeback in IDLE
        writeback(32'hDEAD_BEEF, 5'b11111);
        tick();
        clear_wb();
        settle();
        check("stray_err",       {31'h0, err},        32'd1);
        check("stray_busy",      {31'h0, busy},       32'd0);
        check("stray_out_valid", {31'h0, out_valid},  32'd0);
        check("stray_unit_rdy",  {31'h0, unit_ready}, 32'd1);
        check("stray_result",    result,              32'h3F00_0000);
        check("stray_status",    {27'h0, status},     32'h0);
        repeat (3) tick();
        check("stray_sticky",    {31'h0, err},        32'd1);

        // Latency counter saturation
        in_valid = 1'b1; in_tag = 1'b0;
        tick();
        in_valid = 1'b0;
        repeat (99) tick();
        writeback(32'h42C8_0000, 5'b00001);
        tick();
        clear_wb();
        settle();
        check("sat_lat",       {26'h0, lat},       32'd63);
        check("sat_out_valid", {31'h0, out_valid}, 32'd1);
        check("sat_result",    result,             32'h42C8_0000);
        check("sat_err_keep",  {31'h0, err},       32'd1);

        // Asynchronous reset while holding a result
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", {31'h0, out_valid},  32'd0);
        check("arst_unit_rdy",  {31'h0, unit_ready}, 32'd1);
        check("arst_busy",      {31'h0, busy},       32'd0);
        check("arst_err",       {31'h0, err},        32'd0);
        check("arst_lat",       {26'h0, lat},        32'd0);
        check("arst_result",    result,              32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        in_valid = 1'b1; in_tag = 1'b1;
        settle();
        check("post_start", {31'h0, start}, 32'd1);
        tick();
        in_valid = 1'b0;
        tick();
        writeback(32'h4040_0000, 5'b00010);
        tick();
        clear_wb();
        settle();
        check("post_out_valid", {31'h0, out_valid}, 32'd1);
        check("post_result",    result,             32'h4040_0000);
        check("post_status",    {27'h0, status},    32'h2);
        check("post_tag",       {31'h0, tag},       32'h1);
        check("post_lat",       {26'h0, lat},       32'd2);
        check("post_err",       {31'h0, err},       32'd0);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        settle();
        check("post_drain", {31'h0, busy}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
